// File: rtl/phase_bank.sv
// Double-buffered per-channel phase/enable store: host writes fill a shadow bank,
// and a commit publishes the whole bank to the PWM-facing active bank in one edge.
module phase_bank #(
  parameter int NUM_CHANNELS = 256,
  parameter int PHASE_W      = 8,
  parameter int PHASE_LIMIT  = 256,
  parameter bit SYNC_SWAP    = 1'b1,
  localparam int CHAN_W      = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              wr_valid,
  output logic                              wr_ready,
  input  logic [CHAN_W-1:0]                 wr_chan,
  input  logic [PHASE_W-1:0]                wr_phase,
  input  logic                              wr_en,
  input  logic                              commit,
  input  logic                              period_start,
  input  logic                              err_clr,
  output logic [NUM_CHANNELS*PHASE_W-1:0]   phase_out,
  output logic [NUM_CHANNELS-1:0]           chan_en,
  output logic                              commit_pending,
  output logic                              swap_pulse,
  output logic [15:0]                       frame_cnt,
  output logic                              err_chan,
  output logic                              err_range
);

  localparam logic [CHAN_W:0]  CHAN_LIM  = (CHAN_W+1)'(NUM_CHANNELS);
  localparam logic [PHASE_W:0] PHASE_LIM = (PHASE_W+1)'(PHASE_LIMIT);

  typedef enum logic {LOAD, PENDING} state_t;

  state_t      state_reg;
  logic        swap_pulse_reg;
  logic [15:0] frame_cnt_reg;
  logic        err_chan_reg;
  logic        err_range_reg;

  logic accept;
  logic chan_bad;
  logic phase_bad;
  logic wr_legal;
  logic swap_now;

  assign wr_ready  = (state_reg == LOAD);
  assign accept    = wr_valid && wr_ready;
  // Widened compares so the bounds can equal 2**width without truncating.
  assign chan_bad  = ({1'b0, wr_chan} >= CHAN_LIM);
  assign phase_bad = ({1'b0, wr_phase} >= PHASE_LIM);
  assign wr_legal  = accept && !chan_bad && !phase_bad;

  assign swap_now = ((state_reg == LOAD) && commit && (!SYNC_SWAP || period_start)) ||
                    ((state_reg == PENDING) && period_start);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CHANNELS; gi++) begin : g_chan
      logic               hit;
      logic [PHASE_W-1:0] merge_phase;
      logic               merge_en;
      logic [PHASE_W-1:0] shadow_phase_reg;
      logic               shadow_en_reg;
      logic [PHASE_W-1:0] active_phase_reg;
      logic               active_en_reg;

      // The merged value lets a write in the commit cycle be part of that frame.
      assign hit         = wr_legal && (wr_chan == CHAN_W'(gi));
      assign merge_phase = hit ? wr_phase : shadow_phase_reg;
      assign merge_en    = hit ? wr_en : shadow_en_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          shadow_phase_reg <= '0;
          shadow_en_reg    <= 1'b1;
          active_phase_reg <= '0;
          active_en_reg    <= 1'b1;
        end else begin
          shadow_phase_reg <= merge_phase;
          shadow_en_reg    <= merge_en;
          if (swap_now) begin
            active_phase_reg <= merge_phase;
            active_en_reg    <= merge_en;
          end
        end
      end

      assign phase_out[gi*PHASE_W +: PHASE_W] = active_phase_reg;
      assign chan_en[gi]                      = active_en_reg;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= LOAD;
      swap_pulse_reg <= 1'b0;
      frame_cnt_reg  <= '0;
      err_chan_reg   <= 1'b0;
      err_range_reg  <= 1'b0;
    end else begin
      swap_pulse_reg <= swap_now;
      if (swap_now) begin
        frame_cnt_reg <= frame_cnt_reg + 16'd1;
      end
      case (state_reg)
        LOAD:    if (commit && SYNC_SWAP && !period_start) state_reg <= PENDING;
        PENDING: if (period_start) state_reg <= LOAD;
        default: state_reg <= LOAD;
      endcase
      // A fresh error outranks a simultaneous clear.
      err_chan_reg  <= (accept && chan_bad)  || (err_chan_reg  && !err_clr);
      err_range_reg <= (accept && phase_bad) || (err_range_reg && !err_clr);
    end
  end

  assign commit_pending = (state_reg == PENDING);
  assign swap_pulse     = swap_pulse_reg;
  assign frame_cnt      = frame_cnt_reg;
  assign err_chan       = err_chan_reg;
  assign err_range      = err_range_reg;

endmodule

// File: tb/tb_phase_bank.sv
// Scoreboard bench for phase_bank: a synchronous-swap instance (200 channels) and an
// immediate-swap instance (4 channels) each checked against a bank-level model.
module tb_phase_bank;
  localparam int A_NC = 200, A_PW = 8, A_PL = 200;
  localparam int B_NC = 4,   B_PW = 4, B_PL = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic                   a_wr_valid, a_wr_ready, a_wr_en, a_commit, a_period_start, a_err_clr;
  logic [7:0]             a_wr_chan;
  logic [A_PW-1:0]        a_wr_phase;
  logic [A_NC*A_PW-1:0]   a_phase_out;
  logic [A_NC-1:0]        a_chan_en;
  logic                   a_commit_pending, a_swap_pulse, a_err_chan, a_err_range;
  logic [15:0]            a_frame_cnt;

  logic                   b_wr_valid, b_wr_ready, b_wr_en, b_commit, b_period_start, b_err_clr;
  logic [1:0]             b_wr_chan;
  logic [B_PW-1:0]        b_wr_phase;
  logic [B_NC*B_PW-1:0]   b_phase_out;
  logic [B_NC-1:0]        b_chan_en;
  logic                   b_commit_pending, b_swap_pulse, b_err_chan, b_err_range;
  logic [15:0]            b_frame_cnt;

  phase_bank #(.NUM_CHANNELS(A_NC), .PHASE_W(A_PW), .PHASE_LIMIT(A_PL), .SYNC_SWAP(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .wr_valid(a_wr_valid), .wr_ready(a_wr_ready),
    .wr_chan(a_wr_chan), .wr_phase(a_wr_phase), .wr_en(a_wr_en), .commit(a_commit),
    .period_start(a_period_start), .err_clr(a_err_clr), .phase_out(a_phase_out),
    .chan_en(a_chan_en), .commit_pending(a_commit_pending), .swap_pulse(a_swap_pulse),
    .frame_cnt(a_frame_cnt), .err_chan(a_err_chan), .err_range(a_err_range));

  phase_bank #(.NUM_CHANNELS(B_NC), .PHASE_W(B_PW), .PHASE_LIMIT(B_PL), .SYNC_SWAP(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .wr_valid(b_wr_valid), .wr_ready(b_wr_ready),
    .wr_chan(b_wr_chan), .wr_phase(b_wr_phase), .wr_en(b_wr_en), .commit(b_commit),
    .period_start(b_period_start), .err_clr(b_err_clr), .phase_out(b_phase_out),
    .chan_en(b_chan_en), .commit_pending(b_commit_pending), .swap_pulse(b_swap_pulse),
    .frame_cnt(b_frame_cnt), .err_chan(b_err_chan), .err_range(b_err_range));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- bank-level reference models ----------------
  typedef struct { logic [A_NC*A_PW-1:0] ph; logic [A_NC-1:0] en; logic [15:0] fc; } snap_a_t;
  typedef struct { logic [B_NC*B_PW-1:0] ph; logic [B_NC-1:0] en; logic [15:0] fc; } snap_b_t;

  logic [A_PW-1:0] ash_ph [A_NC];
  bit              ash_en [A_NC];
  bit              a_pend, a_ec, a_er;
  logic [15:0]     a_frame;
  snap_a_t         qa[$];
  snap_a_t         a_last;

  logic [B_PW-1:0] bsh_ph [B_NC];
  bit              bsh_en [B_NC];
  logic [15:0]     b_frame;
  int              b_commits;
  snap_b_t         qb[$];
  snap_b_t         b_last;

  function automatic snap_a_t a_snap();
    snap_a_t s;
    for (int c = 0; c < A_NC; c++) begin
      s.ph[c*A_PW +: A_PW] = ash_ph[c];
      s.en[c] = ash_en[c];
    end
    s.fc = a_frame;
    return s;
  endfunction

  function automatic snap_b_t b_snap();
    snap_b_t s;
    for (int c = 0; c < B_NC; c++) begin
      s.ph[c*B_PW +: B_PW] = bsh_ph[c];
      s.en[c] = bsh_en[c];
    end
    s.fc = b_frame;
    return s;
  endfunction

  task automatic models_reset();
    for (int c = 0; c < A_NC; c++) begin ash_ph[c] = '0; ash_en[c] = 1'b1; end
    for (int c = 0; c < B_NC; c++) begin bsh_ph[c] = '0; bsh_en[c] = 1'b1; end
    a_pend = 0; a_ec = 0; a_er = 0; a_frame = '0; b_frame = '0;
    qa.delete(); qb.delete();
    a_last = a_snap();
    b_last = b_snap();
  endtask

  // One clock of instance A: check status, drive, advance the model, step past the edge.
  task automatic a_cycle(input int v, input int ch, input int ph, input int en,
                         input int cm, input int ps, input int clr);
    bit acc, bc, bp, swap;
    check("a_wr_ready", a_wr_ready, !a_pend);
    check("a_commit_pending", a_commit_pending, a_pend);
    check("a_err_chan", a_err_chan, a_ec);
    check("a_err_range", a_err_range, a_er);
    a_wr_valid = v[0]; a_wr_chan = ch[7:0]; a_wr_phase = ph[7:0]; a_wr_en = en[0];
    a_commit = cm[0]; a_period_start = ps[0]; a_err_clr = clr[0];
    acc = v[0] && !a_pend;
    bc  = ch >= A_NC;
    bp  = ph >= A_PL;
    if (acc && !bc && !bp) begin
      ash_ph[ch] = ph[7:0];
      ash_en[ch] = en[0];
    end
    swap = a_pend ? ps[0] : (cm[0] && ps[0]);
    if (swap) begin
      a_pend = 0;
      a_frame++;
      qa.push_back(a_snap());
    end else if (cm[0] && !a_pend) begin
      a_pend = 1;
    end
    if (clr[0]) begin a_ec = 0; a_er = 0; end
    if (acc && bc) a_ec = 1;
    if (acc && bp) a_er = 1;
    @(posedge clk); #1;
    a_wr_valid = 0; a_commit = 0; a_period_start = 0; a_err_clr = 0;
  endtask

  task automatic a_idle(input int n);
    for (int i = 0; i < n; i++) a_cycle(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic b_cycle(input int v, input int ch, input int ph, input int en, input int cm);
    check("b_wr_ready", b_wr_ready, 1);
    check("b_commit_pending", b_commit_pending, 0);
    b_wr_valid = v[0]; b_wr_chan = ch[1:0]; b_wr_phase = ph[3:0]; b_wr_en = en[0]; b_commit = cm[0];
    if (v[0]) begin
      bsh_ph[ch] = ph[3:0];
      bsh_en[ch] = en[0];
    end
    if (cm[0]) begin
      b_frame++;
      b_commits++;
      qb.push_back(b_snap());
    end
    @(posedge clk); #1;
    b_wr_valid = 0; b_commit = 0;
  endtask

  // ---------------- monitors ----------------
  task automatic a_compare(input string tag);
    int bad_c = -1;
    n_cmp++;
    if (a_phase_out !== a_last.ph || a_chan_en !== a_last.en) begin
      for (int c = 0; c < A_NC; c++)
        if (bad_c < 0 && (a_phase_out[c*A_PW +: A_PW] !== a_last.ph[c*A_PW +: A_PW] ||
                          a_chan_en[c] !== a_last.en[c])) bad_c = c;
      n_bad++;
      if (bad_c < 0) bad_c = 0;
      $display("FAIL %s ch%0d: got phase %0h en %0b expected phase %0h en %0b", tag, bad_c,
               a_phase_out[bad_c*A_PW +: A_PW], a_chan_en[bad_c],
               a_last.ph[bad_c*A_PW +: A_PW], a_last.en[bad_c]);
    end
    check({tag, "_frame"}, a_frame_cnt, a_last.fc);
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (a_swap_pulse) begin
        check("a_swap_expected", qa.size() != 0, 1);
        if (qa.size() != 0) begin
          a_last = qa.pop_front();
          a_compare("a_swap");
        end
      end else begin
        a_compare("a_hold");
      end
      if (b_swap_pulse) begin
        check("b_swap_expected", qb.size() != 0, 1);
        if (qb.size() != 0) begin
          b_last = qb.pop_front();
          check("b_swap_bank", b_phase_out === b_last.ph && b_chan_en === b_last.en, 1);
          check("b_swap_frame", b_frame_cnt, b_last.fc);
        end
      end else begin
        check("b_hold_bank", b_phase_out === b_last.ph && b_chan_en === b_last.en, 1);
        check("b_hold_frame", b_frame_cnt, b_last.fc);
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 0;
    a_wr_valid = 0; a_wr_chan = 0; a_wr_phase = 0; a_wr_en = 0;
    a_commit = 0; a_period_start = 0; a_err_clr = 0;
    b_wr_valid = 0; b_wr_chan = 0; b_wr_phase = 0; b_wr_en = 0;
    b_commit = 0; b_period_start = 0; b_err_clr = 0;
    b_commits = 0;
    models_reset();
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    check("rst_frame", a_frame_cnt, 0);
    check("rst_phase_zero", a_phase_out == '0, 1);
    check("rst_en_ones", &a_chan_en, 1);
    check("rst_swap_pulse", a_swap_pulse, 0);

    // write without commit: active bank untouched
    a_cycle(1, 3, 'h40, 0, 0, 0, 0);
    a_idle(3);
    check("nocommit_ch3_phase", a_phase_out[3*A_PW +: A_PW], 0);
    check("nocommit_ch3_en", a_chan_en[3], 1);
    check("nocommit_frame", a_frame_cnt, 0);

    // commit at t, period_start at t+5; commit and write during PENDING ignored
    a_cycle(0, 0, 0, 0, 1, 0, 0);
    a_cycle(0, 0, 0, 0, 0, 0, 0);
    a_cycle(1, 5, 'h22, 0, 1, 0, 0);
    a_idle(2);
    a_cycle(0, 0, 0, 0, 0, 1, 0);
    check("sync_swap_pulse", a_swap_pulse, 1);
    check("sync_ch3_phase", a_phase_out[3*A_PW +: A_PW], 'h40);
    check("sync_ch3_en", a_chan_en[3], 0);
    check("sync_ch5_untouched", a_phase_out[5*A_PW +: A_PW], 0);
    check("sync_frame", a_frame_cnt, 1);

    // write + commit + period_start together: immediate swap including the write
    a_cycle(1, 0, 'h10, 1, 1, 1, 0);
    check("coinc_swap_pulse", a_swap_pulse, 1);
    check("coinc_ch0_phase", a_phase_out[0 +: A_PW], 'h10);
    check("coinc_no_pending", a_commit_pending, 0);
    check("coinc_frame", a_frame_cnt, 2);

    // range checks and sticky flags
    a_cycle(1, A_NC, 5, 1, 0, 0, 0);
    a_cycle(1, 7, A_PL, 1, 0, 0, 0);
    a_cycle(1, A_NC - 1, A_PL - 1, 0, 0, 0, 0);
    check("err_both_chan", a_err_chan, 1);
    check("err_both_range", a_err_range, 1);
    a_cycle(1, A_NC + 1, 3, 1, 0, 0, 1);
    check("err_clr_new_chan", a_err_chan, 1);
    check("err_clr_range", a_err_range, 0);
    a_cycle(0, 0, 0, 0, 0, 0, 1);
    a_cycle(1, 250, 250, 1, 0, 0, 0);
    a_cycle(0, 0, 0, 0, 1, 1, 1);
    a_idle(2);

    // randomized traffic on instance A
    for (int i = 0; i < 400; i++)
      a_cycle($urandom_range(0, 1), $urandom_range(0, A_NC + 9), $urandom_range(0, A_PL + 19),
              $urandom_range(0, 1), $urandom_range(0, 9) == 0, $urandom_range(0, 6) == 0,
              $urandom_range(0, 19) == 0);

    // reset in the middle of a pending commit
    a_cycle(0, 0, 0, 0, 0, 1, 0);
    a_cycle(1, 9, 'h55, 0, 1, 0, 0);
    a_idle(2);
    #2 rst_n = 0;
    models_reset();
    #1;
    check("midrst_wr_ready", a_wr_ready, 1);
    check("midrst_pending", a_commit_pending, 0);
    check("midrst_phase_zero", a_phase_out == '0, 1);
    check("midrst_en_ones", &a_chan_en, 1);
    check("midrst_frame", a_frame_cnt, 0);
    @(negedge clk); #1 rst_n = 1;
    @(posedge clk); #1;
    a_cycle(0, 0, 0, 0, 0, 1, 0);
    a_idle(2);
    check("postrst_frame", a_frame_cnt, 0);

    // instance B: immediate swaps, random then back-to-back commits to 0x10000
    for (int i = 0; i < 100; i++)
      b_cycle($urandom_range(0, 1), $urandom_range(0, B_NC - 1), $urandom_range(0, B_PL - 1),
              $urandom_range(0, 1), $urandom_range(0, 9) < 3);
    while (b_commits < 65536)
      b_cycle($urandom_range(0, 1), $urandom_range(0, B_NC - 1), $urandom_range(0, B_PL - 1),
              $urandom_range(0, 1), 1);
    check("b_frame_wrap", b_frame_cnt, 0);
    check("b_wrap_pulse", b_swap_pulse, 1);
    check("b_err_chan", b_err_chan, 0);
    check("b_err_range", b_err_range, 0);
    repeat (3) begin @(posedge clk); #1; end

    check("a_queue_drained", qa.size(), 0);
    check("b_queue_drained", qb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/phase_bank.md
Name: phase_bank

Overview:
- Double-buffered per-channel phase/enable store for the transducer array; successor to the flat single-bank phase registers.
- The host-side parser writes (channel, phase, enable) entries into a shadow bank. A commit copies the whole shadow bank to the active bank atomically, either immediately or at the next PWM period boundary.
- Active outputs drive the PWM channels directly, so a half-written frame is never emitted.
- Adds range checking, sticky error flags and a frame counter.

Parameters:
- NUM_CHANNELS, 256, number of transducer channels.
- PHASE_W, 8, phase word width in clock counts.
- PHASE_LIMIT, 256, exclusive upper bound on a legal phase (equals PWM period in counts); must be <= 2**PHASE_W.
- SYNC_SWAP, 1, 1 = swap waits for period_start; 0 = swap on the commit edge.
- Derived localparam CHAN_W = $clog2(NUM_CHANNELS), minimum 1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- wr_valid  in  1  write entry valid.
- wr_ready  out  1  entry can be accepted.
- wr_chan  in  CHAN_W  target channel index.
- wr_phase  in  PHASE_W  phase value.
- wr_en  in  1  channel enable bit for the entry.
- commit  in  1  single-cycle request to publish the shadow bank.
- period_start  in  1  one-cycle pulse at PWM counter wrap.
- err_clr  in  1  clears sticky error flags.
- phase_out  out  NUM_CHANNELS*PHASE_W  active phases; channel i occupies bits [i*PHASE_W +: PHASE_W].
- chan_en  out  NUM_CHANNELS  active enables.
- commit_pending  out  1  commit accepted, swap not yet done.
- swap_pulse  out  1  high for one cycle after each swap edge.
- frame_cnt  out  16  number of swaps, wraps 0xFFFF->0.
- err_chan  out  1  sticky: write with wr_chan >= NUM_CHANNELS.
- err_range  out  1  sticky: write with wr_phase >= PHASE_LIMIT.

Behaviour:
- Reset (rst_n low, async):
  - Both banks phase = 0 and enable = 1 for all channels.
  - State = LOAD.
  - commit_pending = 0, swap_pulse = 0, frame_cnt = 0, err_chan = 0, err_range = 0.
  - Reset mid-PENDING discards the pending commit.
- States: LOAD and PENDING.
- wr_ready:
  - Equals 1 in LOAD, 0 in PENDING; combinational from state only.
  - A write is accepted when wr_valid && wr_ready.
- Accepted write:
  - Legal entry: shadow[wr_chan] takes {wr_phase, wr_en} at that edge.
  - Illegal channel: entry dropped, err_chan <= 1.
  - Illegal phase: entry dropped, err_range <= 1.
  - Both illegal: both flags set.
  - Repeated writes to one channel: last one wins.
- Commit in LOAD with SYNC_SWAP=0:
  - At that edge, active <= shadow, with any same-cycle accepted write merged in.
  - swap_pulse = 1 in the next cycle; frame_cnt increments.
  - State stays LOAD.
- Commit in LOAD with SYNC_SWAP=1 and period_start=0:
  - Same-cycle write lands in shadow.
  - State -> PENDING; commit_pending = 1 from the next cycle.
- Commit in LOAD with SYNC_SWAP=1 and period_start=1: swaps immediately, as in SYNC_SWAP=0.
- PENDING with period_start=1: active <= shadow, swap_pulse 1 next cycle, frame_cnt++, commit_pending -> 0, state -> LOAD.
- Commit while PENDING is ignored (no queueing, no error).
- After a swap, shadow keeps its contents, so later frames may update only some channels.
- Active outputs change only on swap edges: phase_out/chan_en update in the same cycle swap_pulse rises.
- Sticky errors:
  - err_clr clears both flags.
  - A new error in the same cycle as err_clr wins: the flag is set.
- period_start outside PENDING, and not coincident with a commit, has no effect.
- All outputs are registered except wr_ready.

Test Plan:
- Reset, then write ch3 = 0x40 en=0 with no commit -> phase_out ch3 stays 0x00, chan_en[3] = 1, frame_cnt = 0.
- SYNC_SWAP=1: write ch3 = 0x40, commit at t, period_start at t+5 -> wr_ready low t+1..t+5, commit_pending high t+1..t+5, ch3 = 0x40 and swap_pulse high at t+6, frame_cnt = 1.
- Write ch0 = 0x10 in the same cycle as commit and period_start -> swap includes ch0 = 0x10, commit_pending never asserts.
- Write wr_chan = NUM_CHANNELS (when NUM_CHANNELS is a power-of-two, use a non-power-of-two config such as 200 so the index fits CHAN_W), then wr_phase = PHASE_LIMIT -> both entries dropped, err_chan = err_range = 1. Assert err_clr together with a new bad-channel write -> err_chan stays 1, err_range = 0.
- Commit at PENDING, pulse rst_n low mid-wait -> all phases 0, enables 1, state LOAD, wr_ready = 1.
- Drive 0x10000 commits with SYNC_SWAP=0 -> frame_cnt wraps to 0 on the last swap.
